// File: rtl/pio_in_pkg.sv
// Shared constants for the KEY/SW input PIO: register map, bit layout and width.
package pio_in_pkg;

    localparam int REG_W = 12;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_RAW  = 2'd3;

    localparam int KEY_LSB = 0;
    localparam int SW_LSB  = 2;

    function automatic logic [31:0] zext_reg(input logic [REG_W-1:0] v);
        return {{(32-REG_W){1'b0}}, v};
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchroniser followed by a stable-count debouncer.
module debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk_clk,
    input  logic reset_reset,
    input  logic din,
    output logic sync,
    output logic dout
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic [CNT_W-1:0] cnt;

    // NOTE: every sequential assignment uses <= so all flops sample pre-edge values.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            meta <= RESET_VAL;
            sync <= RESET_VAL;
            dout <= RESET_VAL;
            cnt  <= '0;
        end else begin
            meta <= din;
            sync <= meta;
            if (sync == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // Level has disagreed for DEBOUNCE_CYCLES consecutive cycles: accept it.
                dout <= sync;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/key_switch_input_pio.sv
// Avalon-MM responder returning debounced DE10-Lite KEY/SW state with edge capture and IRQ.
module key_switch_input_pio
    import pio_in_pkg::*;
#(
    parameter int N_KEY           = 2,
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [N_KEY-1:0]  key_n_in,
    input  logic [N_SW-1:0]   sw_in,
    input  logic [1:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              avs_readdatavalid,
    output logic              avs_waitrequest,
    output logic              irq
);

    localparam logic [REG_W-1:0] KEY_BITS = REG_W'(((1 << N_KEY) - 1) << KEY_LSB);

    logic [N_KEY-1:0] key_sync_n, key_stable_n;
    logic [N_SW-1:0]  sw_sync, sw_stable;

    // Key flops idle at 1 (released) so the inverted level starts at 0.
    for (genvar i = 0; i < N_KEY; i++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VAL      (1'b1)
        ) u_db (
            .clk_clk    (clk_clk),
            .reset_reset(reset_reset),
            .din        (key_n_in[i]),
            .sync       (key_sync_n[i]),
            .dout       (key_stable_n[i])
        );
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VAL      (1'b0)
        ) u_db (
            .clk_clk    (clk_clk),
            .reset_reset(reset_reset),
            .din        (sw_in[i]),
            .sync       (sw_sync[i]),
            .dout       (sw_stable[i])
        );
    end

    logic [REG_W-1:0] stable, raw, stable_d, edge_q, mask_q, edge_set, edge_clr;
    logic [31:0]      rd_mux;
    logic             unused_wdata_hi;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        stable = '0;
        raw    = '0;
        stable[KEY_LSB +: N_KEY] = ~key_stable_n;
        stable[SW_LSB  +: N_SW]  = sw_stable;
        raw[KEY_LSB +: N_KEY]    = ~key_sync_n;
        raw[SW_LSB  +: N_SW]     = sw_sync;
    end

    // Keys capture presses only; switches capture any change.
    assign edge_set = (stable & ~stable_d & KEY_BITS) | ((stable ^ stable_d) & ~KEY_BITS);
    assign edge_clr = (avs_write && avs_address == ADDR_EDGE) ? avs_writedata[REG_W-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_DATA: rd_mux = zext_reg(stable);
            ADDR_MASK: rd_mux = zext_reg(mask_q);
            ADDR_EDGE: rd_mux = zext_reg(edge_q);
            ADDR_RAW:  rd_mux = zext_reg(raw);
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            stable_d          <= '0;
            edge_q            <= '0;
            mask_q            <= '0;
            irq               <= 1'b0;
            avs_readdatavalid <= 1'b0;
            avs_readdata      <= '0;
        end else begin
            stable_d <= stable;
            // A set in the same cycle as a W1C of that bit wins.
            edge_q   <= (edge_q & ~edge_clr) | edge_set;
            if (avs_write && avs_address == ADDR_MASK) begin
                mask_q <= avs_writedata[REG_W-1:0];
            end
            irq               <= |(edge_q & mask_q);
            avs_readdatavalid <= avs_read;
            if (avs_read) begin
                avs_readdata <= rd_mux;
            end
        end
    end

    assign avs_waitrequest = 1'b0;
    assign unused_wdata_hi = ^avs_writedata[31:REG_W];

endmodule
